// File: rtl/topk_search_controller.sv
`default_nettype none
// ============================================================================
// Module      : topk_search_controller
// Description : Sequences one top-K retrieval query. Scored candidates are
//               buffered in a small skid FIFO. Each candidate that can still
//               enter the top-K is pushed to the priority queue, one at a
//               time. Candidates that cannot enter are pruned. Per-query
//               statistics are kept, and the query ends with a completion
//               pulse or a sticky timeout error.
// Ports       : clk, rst                      clock, sync active-high reset
//               query_start/query_abort       query control
//               cand_valid/ready/sim/idx/last candidate stream in
//               pq_clear/push/sim/idx         priority-queue command out
//               pq_done, pq_kth_sim           priority-queue status in
//               busy, query_done, error       query status out
//               cand/push/prune_count         saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module topk_search_controller #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              query_start,
  input  logic              query_abort,
  input  logic              cand_valid,
  output logic              cand_ready,
  input  logic [31:0]       cand_sim,
  input  logic [31:0]       cand_idx,
  input  logic              cand_last,
  output logic              pq_clear,
  output logic              pq_push,
  output logic [31:0]       pq_sim,
  output logic [31:0]       pq_idx,
  input  logic              pq_done,
  input  logic [31:0]       pq_kth_sim,
  output logic              busy,
  output logic              query_done,
  output logic              error,
  output logic [CNT_W-1:0]  cand_count,
  output logic [CNT_W-1:0]  push_count,
  output logic [CNT_W-1:0]  prune_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [PTR_W:0]   C_DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  state_e state_q, state_d;

  // FIFO entry layout: {last, idx, sim}
  logic [64:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     fifo_cnt_q;
  logic               last_seen_q, last_reg_q, error_q;
  logic [TMR_W-1:0]   timer_q;
  logic [31:0]        pq_sim_q, pq_idx_q;
  logic [CNT_W-1:0]   cand_cnt_q, push_cnt_q, prune_cnt_q;

  logic        fifo_empty, fifo_full, accepting, fifo_wr, fifo_flush;
  logic [31:0] head_sim, head_idx;
  logic        head_last;
  logic        do_start, do_pop, do_prune, do_latch, do_timeout;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == C_DEPTH);
  assign {head_last, head_idx, head_sim} = fifo_mem_q[rd_ptr_q];

  // Intake closes once the final beat of the query has been accepted.
  assign accepting = ((state_q == S_CLEAR) || (state_q == S_FETCH) ||
                      (state_q == S_ISSUE) || (state_q == S_WAIT)) && !last_seen_q;
  assign cand_ready = accepting && !fifo_full;
  assign fifo_wr    = cand_valid && cand_ready;

  assign do_start   = (state_q == S_IDLE) && query_start && !query_abort;
  assign fifo_flush = query_abort || (state_q == S_ERROR) || do_start;

  always_comb begin
    state_d    = state_q;
    pq_clear   = 1'b0;
    pq_push    = 1'b0;
    query_done = 1'b0;
    do_pop     = 1'b0;
    do_prune   = 1'b0;
    do_latch   = 1'b0;
    do_timeout = 1'b0;
    case (state_q)
      S_IDLE:  if (query_start) state_d = S_CLEAR;
      S_CLEAR: begin
        pq_clear = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: if (!fifo_empty) begin
        do_pop = 1'b1;
        // A score equal to the current K-th score cannot displace it.
        if (head_sim <= pq_kth_sim) begin
          do_prune = 1'b1;
          if (head_last) state_d = S_FINISH;
        end else begin
          do_latch = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pq_push = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pq_done) begin
          state_d = last_reg_q ? S_FINISH : S_FETCH;
        end else if (timer_q == C_TMR_LAST) begin
          do_timeout = 1'b1;
          state_d    = S_ERROR;
        end
      end
      S_FINISH: begin
        query_done = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERROR: if (query_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything and suppresses any side effect of this cycle.
    if (query_abort) begin
      state_d    = S_IDLE;
      pq_clear   = 1'b0;
      pq_push    = 1'b0;
      query_done = 1'b0;
      do_pop     = 1'b0;
      do_prune   = 1'b0;
      do_latch   = 1'b0;
      do_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= {cand_last, cand_idx, cand_sim};
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_wr, do_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || do_start)            last_seen_q <= 1'b0;
    else if (fifo_wr && cand_last)  last_seen_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg_q <= 1'b0;
      pq_sim_q   <= '0;
      pq_idx_q   <= '0;
    end else if (do_latch) begin
      last_reg_q <= head_last;
      pq_sim_q   <= head_sim;
      pq_idx_q   <= head_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_q == S_ISSUE)) timer_q <= '0;
    else if (state_q == S_WAIT)      timer_q <= timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) error_q <= 1'b0;
    else if (query_abort ||
             (query_start && ((state_q == S_IDLE) || (state_q == S_ERROR))))
      error_q <= 1'b0;
    else if (do_timeout)
      error_q <= 1'b1;
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || do_start) begin
      cand_cnt_q  <= '0;
      push_cnt_q  <= '0;
      prune_cnt_q <= '0;
    end else begin
      if (do_pop && (cand_cnt_q != '1))    cand_cnt_q  <= cand_cnt_q + C_CNT_ONE;
      if (pq_push && (push_cnt_q != '1))   push_cnt_q  <= push_cnt_q + C_CNT_ONE;
      if (do_prune && (prune_cnt_q != '1)) prune_cnt_q <= prune_cnt_q + C_CNT_ONE;
    end
  end

  assign pq_sim      = pq_sim_q;
  assign pq_idx      = pq_idx_q;
  assign busy        = (state_q != S_IDLE);
  assign error       = error_q;
  assign cand_count  = cand_cnt_q;
  assign push_count  = push_cnt_q;
  assign prune_count = prune_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_topk_search_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_topk_search_controller
// Description : Scoreboard bench for topk_search_controller. The stimulus side
//               predicts which candidates survive pruning (score > K-th score)
//               and the per-query statistics; a monitor compares each pq_push
//               and query_done against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_topk_search_controller;

  localparam int FD = 8;
  localparam int TO = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          query_start, query_abort;
  logic          cand_valid, cand_ready, cand_last;
  logic [31:0]   cand_sim, cand_idx;
  logic          pq_clear, pq_push, pq_done;
  logic [31:0]   pq_sim, pq_idx, pq_kth_sim;
  logic          busy, query_done, error;
  logic [CW-1:0] cand_count, push_count, prune_count;

  topk_search_controller #(.FIFO_DEPTH(FD), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .query_start(query_start), .query_abort(query_abort),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_sim(cand_sim), .cand_idx(cand_idx), .cand_last(cand_last),
    .pq_clear(pq_clear), .pq_push(pq_push), .pq_sim(pq_sim), .pq_idx(pq_idx),
    .pq_done(pq_done), .pq_kth_sim(pq_kth_sim),
    .busy(busy), .query_done(query_done), .error(error),
    .cand_count(cand_count), .push_count(push_count), .prune_count(prune_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_push_q [$];   // {idx, sim}
  logic [95:0] exp_done_q [$];   // {cand, push, prune}
  logic [31:0] stim_sim   [$];
  logic [63:0] mon_e;
  logic [95:0] mon_d;
  int          done_dly  = 0;    // 0 selects a random response delay
  bit          hold_done = 1'b0;
  bit          saw_bp    = 1'b0;
  int          next_idx  = 1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every push and completion must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (pq_push) begin
        if (exp_push_q.size() == 0) check("unexpected_push", 64'd1, 64'd0);
        else begin
          mon_e = exp_push_q.pop_front();
          check("push_sim", {32'd0, pq_sim}, {32'd0, mon_e[31:0]});
          check("push_idx", {32'd0, pq_idx}, {32'd0, mon_e[63:32]});
        end
      end
      if (query_done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          mon_d = exp_done_q.pop_front();
          check("done_cand",  {32'd0, cand_count},  {32'd0, mon_d[95:64]});
          check("done_push",  {32'd0, push_count},  {32'd0, mon_d[63:32]});
          check("done_prune", {32'd0, prune_count}, {32'd0, mon_d[31:0]});
        end
      end
    end
  end

  // Priority-queue responder: one done pulse per push after a delay.
  initial begin
    int d;
    pq_done = 1'b0;
    forever begin
      @(negedge clk);
      if (pq_push && !hold_done) begin
        d = (done_dly == 0) ? int'($urandom_range(1, 8)) : done_dly;
        repeat (d) @(posedge clk);
        #1 pq_done = 1'b1;
        @(posedge clk);
        #1 pq_done = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic drive_beat(input logic [31:0] s, input logic [31:0] idx, input logic last);
    int guard;
    guard = 0;
    cand_valid = 1'b1; cand_sim = s; cand_idx = idx; cand_last = last;
    forever begin
      @(negedge clk);
      if (cand_ready) begin
        @(posedge clk); #1;
        break;
      end
      saw_bp = 1'b1;
      guard++;
      if (guard > 3000) begin
        check("beat_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    cand_valid = 1'b0; cand_last = 1'b0;
  endtask

  task automatic pulse_start();
    query_start = 1'b1;
    @(posedge clk); #1;
    query_start = 1'b0;
  endtask

  task automatic pulse_abort();
    query_abort = 1'b1;
    @(posedge clk); #1;
    query_abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  // Full query over stim_sim with the K-th score held at kth.
  task automatic run_query(input logic [31:0] kth, input bit gaps, input bit chk_clr);
    int c, p, r, n, base;
    c = 0; p = 0; r = 0;
    n = stim_sim.size();
    base = next_idx;
    next_idx += n;
    pq_kth_sim = kth;
    for (int i = 0; i < n; i++) begin
      c++;
      if (stim_sim[i] > kth) begin
        p++;
        exp_push_q.push_back({32'(base + i), stim_sim[i]});
      end else r++;
    end
    exp_done_q.push_back({32'(c), 32'(p), 32'(r)});
    pulse_start();
    if (chk_clr) begin
      @(negedge clk);
      check("clear_pulse", {63'd0, pq_clear}, 64'd1);
      check("busy_in_clear", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("clear_one_cycle", {63'd0, pq_clear}, 64'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      drive_beat(stim_sim[i], 32'(base + i), (i == n - 1));
    end
    wait_idle(5000);
    check("push_queue_drained", 64'(exp_push_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
    check("final_cand",  {32'd0, cand_count},  64'(c));
    check("final_push",  {32'd0, push_count},  64'(p));
    check("final_prune", {32'd0, prune_count}, 64'(r));
  endtask

  initial begin
    int n, guard;
    bit err_early;
    rst = 1'b1; query_start = 1'b0; query_abort = 1'b0;
    cand_valid = 1'b0; cand_sim = '0; cand_idx = '0; cand_last = 1'b0;
    pq_kth_sim = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  {63'd0, busy},       64'd0);
    check("rst_ready", {63'd0, cand_ready}, 64'd0);
    check("rst_push",  {63'd0, pq_push},    64'd0);
    check("rst_clear", {63'd0, pq_clear},   64'd0);
    check("rst_done",  {63'd0, query_done}, 64'd0);
    check("rst_error", {63'd0, error},      64'd0);
    check("rst_cnts",  {32'd0, cand_count | push_count | prune_count}, 64'd0);
    check("rst_pq",    {pq_sim, pq_idx},    64'd0);
    @(posedge clk); #1;

    // 1: three candidates, nothing pruned, done 4 cycles after each push
    done_dly = 4;
    stim_sim = '{32'd10, 32'd30, 32'd20};
    run_query(32'd0, 1'b0, 1'b1);

    // 2: K-th score 25 prunes 10 and the tie at 25
    stim_sim = '{32'd10, 32'd25, 32'd40};
    run_query(32'd25, 1'b0, 1'b0);

    // 3: missing done -> timeout error, then abort
    hold_done = 1'b1;
    pq_kth_sim = '0;
    exp_push_q.push_back({32'(next_idx), 32'd5});
    pulse_start();
    drive_beat(32'd5, 32'(next_idx), 1'b1);
    next_idx++;
    guard = 0;
    @(negedge clk);
    while (!pq_push && guard < 20) begin @(negedge clk); guard++; end
    check("t3_push_seen", {63'd0, pq_push}, 64'd1);
    err_early = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (error) err_early = 1'b1;
    end
    check("t3_error_not_early", {63'd0, err_early}, 64'd0);
    @(negedge clk);
    check("t3_error_set", {63'd0, error}, 64'd1);
    check("t3_ready_low", {63'd0, cand_ready}, 64'd0);
    check("t3_busy_err",  {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    pulse_abort();
    @(negedge clk);
    check("t3_idle_after_abort", {63'd0, busy}, 64'd0);
    check("t3_error_cleared",    {63'd0, error}, 64'd0);
    check("t3_cnts_held", {32'd0, cand_count}, 64'd1);
    @(posedge clk); #1;
    hold_done = 1'b0;

    // 4: 12 back-to-back beats, slow queue -> back-pressure, order kept
    done_dly = 6;
    saw_bp = 1'b0;
    stim_sim.delete();
    for (int i = 0; i < 12; i++) stim_sim.push_back(32'(100 + $urandom_range(1, 900)));
    run_query(32'd50, 1'b0, 1'b0);
    check("t4_backpressure", {63'd0, saw_bp}, 64'd1);

    // 5: abort in WAIT_DONE with 3 beats still buffered
    hold_done = 1'b1;
    done_dly = 0;
    pq_kth_sim = '0;
    exp_push_q.push_back({32'(next_idx), 32'd77});
    pulse_start();
    drive_beat(32'd77, 32'(next_idx),     1'b0);
    drive_beat(32'd78, 32'(next_idx + 1), 1'b0);
    drive_beat(32'd79, 32'(next_idx + 2), 1'b0);
    drive_beat(32'd80, 32'(next_idx + 3), 1'b1);
    next_idx += 4;
    repeat (3) begin @(posedge clk); #1; end
    pulse_abort();
    @(negedge clk);
    check("t5_idle", {63'd0, busy}, 64'd0);
    check("t5_cand_cnt", {32'd0, cand_count}, 64'd1);
    check("t5_push_cnt", {32'd0, push_count}, 64'd1);
    repeat (20) @(negedge clk);
    check("t5_no_extra_push", 64'(exp_push_q.size()), 64'd0);
    @(posedge clk); #1;
    hold_done = 1'b0;
    // a fresh query must see only its own beat, proving the flush
    stim_sim = '{32'd300};
    run_query(32'd0, 1'b0, 1'b0);

    // 6: single zero-score candidate is pruned
    stim_sim = '{32'd0};
    run_query(32'd0, 1'b0, 1'b0);

    // randomized queries
    for (int q = 0; q < 8; q++) begin
      n = $urandom_range(1, 14);
      stim_sim.delete();
      for (int i = 0; i < n; i++) stim_sim.push_back(32'($urandom_range(0, 200)));
      run_query(32'($urandom_range(0, 120)), 1'b1, 1'b0);
    end

    check("end_push_queue", 64'(exp_push_q.size()), 64'd0);
    check("end_done_queue", 64'(exp_done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
